hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 16-bit RISC core.
- Drives the write-enable and flush of the IF_ID register, the PC write-enable and the ID/EX bubble insertion.
- Resolves load-use hazards (multi-cycle stall), taken-branch flushes and data-memory wait states, and keeps a saturating stall-cycle counter for debug.
- Sits beside the IF_ID / ID_EX registers. Consumes register fields decoded from the IF_ID output and status from the EX and MEM stages.

Parameters:
- REG_AW, 3, register-address width (8 architectural registers; r0 hard-wired zero).
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..15).
- MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before error (legal 1..65535).
- CNT_W, 16, stall counter width.

Ports:
- inp_clk, in, 1, clock; all state updates on the rising edge.
- inp_reset_n, in, 1, asynchronous active-low reset.
- inp_if_id_rs1, in, REG_AW, source register 1 of the instruction in ID.
- inp_if_id_rs2, in, REG_AW, source register 2 of the instruction in ID.
- inp_uses_rs2, in, 1, the ID instruction actually reads rs2.
- inp_id_ex_rd, in, REG_AW, destination of the instruction in EX.
- inp_id_ex_mem_read, in, 1, the EX instruction is a load.
- inp_branch_taken, in, 1, the EX-stage branch/jump resolved taken this cycle.
- inp_mem_req, in, 1, the MEM stage is issuing a data-memory access.
- inp_mem_ready, in, 1, the data memory completes the access this cycle.
- inp_clr_cnt, in, 1, synchronous clear of out_stall_cycles.
- out_pc_write, out, 1, PC register enable.
- out_if_id_write, out, 1, IF_ID register enable.
- out_if_id_flush, out, 1, IF_ID loads NOP (0x0000) on the next edge.
- out_id_ex_write, out, 1, ID/EX register enable.
- out_id_ex_bubble, out, 1, ID/EX loads control-zero bubble.
- out_mem_error, out, 1, sticky memory-timeout flag.
- out_stall_cycles, out, CNT_W, saturating count of cycles with out_pc_write=0.

Behaviour:
- States: RUN, LSTALL, MWAIT, ERR. Reset (async, inp_reset_n=0) forces RUN, load counter=0, timeout counter=0, out_mem_error=0, out_stall_cycles=0.
- Outputs are Mealy (state + current inputs), combinational, and valid in the same cycle. Reset-state values: pc_write=1, if_id_write=1, id_ex_write=1, flush=0, bubble=0.
- The hazard predicate is evaluated in the order below; the first match decides the cycle.
- 1. Memory wait (inp_mem_req=1 and inp_mem_ready=0, in RUN or LSTALL):
  - Freeze everything: pc_write=0, if_id_write=0, id_ex_write=0, flush=0, bubble=0.
  - Next state MWAIT, timeout counter=1.
  - A stall in progress in LSTALL resumes after MWAIT with its load counter preserved.
- 2. Branch (inp_branch_taken=1):
  - pc_write=1, if_id_write=1, flush=1, bubble=1.
  - Next state RUN; any pending LSTALL is abandoned (the load counter is cleared).
- 3. Load-use (state RUN, inp_id_ex_mem_read=1, inp_id_ex_rd!=0, and rd==rs1 or (inp_uses_rs2 and rd==rs2)):
  - pc_write=0, if_id_write=0, bubble=1.
  - If LOAD_STALL_CYCLES>1: next state LSTALL, load counter=LOAD_STALL_CYCLES-1. Otherwise stay in RUN.
- LSTALL (no higher-priority event):
  - Same outputs as a load-use stall.
  - Counter decrements each cycle; the cycle in which it equals 1 is the last stall cycle, and the next state is RUN.
  - The hazard predicate is not re-evaluated inside LSTALL.
- MWAIT:
  - Freeze outputs while inp_mem_ready=0; timeout counter increments.
  - On inp_mem_ready=1, the freeze holds in that cycle; next state is LSTALL if the load counter is nonzero, else RUN.
  - If the timeout counter reaches MEM_TIMEOUT with ready still 0: next state ERR, out_mem_error=1.
  - inp_branch_taken is ignored while frozen, since the EX stage is held.
- ERR:
  - All enables 0, flush=0, bubble=0.
  - Leaves only via reset; out_mem_error stays 1.
- out_stall_cycles:
  - Increments every cycle with out_pc_write=0 and saturates at all-ones.
  - inp_clr_cnt=1 zeroes it and has priority over increment.
- rd==0 never creates a hazard.
- A simultaneous branch and load-use resolves as a branch: no stall.

Decomposition:
- Shared package riscs_pipe_pkg holds:
  - the state enum (RUN/LSTALL/MWAIT/ERR) and NOP_INSTR=16'h0000;
  - REG_AW default, also shared with the decoder and register file.
- Sub-module hazard_detect: purely combinational load-use comparator (rs1, rs2, uses_rs2, rd, mem_read -> hit).
- The FSM, the load and timeout counters and the stall counter stay in hazard_ctrl.

Test Plan:
- Reset: hold inp_reset_n=0 mid-cycle with random inputs -> immediately pc_write=1, if_id_write=1, flush=0, bubble=0, stall_cycles=0, mem_error=0.
- Load-use, LOAD_STALL_CYCLES=2: rd=3, mem_read=1, rs1=3 -> pc_write=0 and bubble=1 for exactly 2 cycles, then RUN; stall_cycles=2. Repeat with rd=0 -> no stall.
- Branch vs load-use same cycle: branch_taken=1, mem_read=1, rd=rs2=5, uses_rs2=1 -> flush=1, bubble=1, pc_write=1; no stall next cycle.
- Memory wait: mem_req=1, ready=0 for 4 cycles then ready=1 -> all enables 0 for 5 cycles, then RUN; stall_cycles=5.
- Timeout, MEM_TIMEOUT=8: mem_req=1, ready never -> ERR entered and mem_error=1 after 8 wait cycles; remains set until inp_reset_n=0.
- Counter saturation, CNT_W=4: 20 stall cycles -> out_stall_cycles=15; then inp_clr_cnt=1 -> 0 on the next edge.

Source files
------------

// File: rtl/riscs_pipe_pkg.sv
// Shared definitions for the 16-bit RISC pipeline: register-address width,
// the NOP encoding, and the pipeline sequencing state type.
package riscs_pipe_pkg;

    // Default register-address width (8 architectural registers, r0 reads zero)
    localparam int PIPE_REG_AW = 3;

    // Encoding loaded into IF_ID when it is flushed
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MWAIT  = 2'd2,
        ERR    = 2'd3
    } pipe_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. r0 never creates a dependency.
module hazard_detect
    import riscs_pipe_pkg::*;
#(
    parameter int REG_AW = PIPE_REG_AW
) (
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              uses_rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              mem_read,
    output logic              hit
);

    // Hazard when a load writes a register the ID instruction actually reads
    assign hit = mem_read && (rd != '0) &&
                 ((rd == rs1) || (uses_rs2 && (rd == rs2)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF_ID / ID_EX enables, IF_ID flush
// and ID_EX bubble, with load-use stalls, branch flushes, data-memory wait
// states, a memory timeout trap and a saturating stall-cycle counter.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   RUN    | normal issue; load-use hazards detected here
//   LSTALL | remaining bubbles of a multi-cycle load-use stall
//   MWAIT  | pipeline frozen waiting for data memory; timeout running
//   ERR    | memory timed out; pipeline dead until reset
module hazard_ctrl
    import riscs_pipe_pkg::*;
#(
    parameter int REG_AW            = PIPE_REG_AW,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255,
    parameter int CNT_W             = 16
) (
    input  logic              inp_clk,
    input  logic              inp_reset_n,
    input  logic [REG_AW-1:0] inp_if_id_rs1,
    input  logic [REG_AW-1:0] inp_if_id_rs2,
    input  logic              inp_uses_rs2,
    input  logic [REG_AW-1:0] inp_id_ex_rd,
    input  logic              inp_id_ex_mem_read,
    input  logic              inp_branch_taken,
    input  logic              inp_mem_req,
    input  logic              inp_mem_ready,
    input  logic              inp_clr_cnt,
    output logic              out_pc_write,
    output logic              out_if_id_write,
    output logic              out_if_id_flush,
    output logic              out_id_ex_write,
    output logic              out_id_ex_bubble,
    output logic              out_mem_error,
    output logic [CNT_W-1:0]  out_stall_cycles
);

    // Load counter reload: bubbles still owed after the detecting cycle
    localparam logic [3:0]  LCNT_LOAD = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [16:0] TIMEOUT   = 17'(MEM_TIMEOUT);

    pipe_state_t state, state_nxt;
    logic [3:0]  lcnt, lcnt_nxt;
    logic [15:0] tcnt, tcnt_nxt;
    logic [16:0] tcnt_inc;
    logic        load_hit;
    logic        mem_wait;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_detect (
        .rs1      (inp_if_id_rs1),
        .rs2      (inp_if_id_rs2),
        .uses_rs2 (inp_uses_rs2),
        .rd       (inp_id_ex_rd),
        .mem_read (inp_id_ex_mem_read),
        .hit      (load_hit)
    );

    assign mem_wait = inp_mem_req && !inp_mem_ready;
    assign tcnt_inc = {1'b0, tcnt} + 17'd1;

    // State, load counter and timeout counter registers
    always_ff @(posedge inp_clk or negedge inp_reset_n) begin
        if (!inp_reset_n) begin
            state <= RUN;
            lcnt  <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            lcnt  <= lcnt_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    // Next-state and counter update; memory wait outranks branch, which outranks load-use
    always_comb begin
        state_nxt = state;
        lcnt_nxt  = lcnt;
        tcnt_nxt  = tcnt;
        case (state)
            RUN, LSTALL: begin
                if (mem_wait) begin
                    // this cycle is the first wait cycle; the load counter is kept
                    tcnt_nxt  = 16'd1;
                    state_nxt = (TIMEOUT <= 17'd1) ? ERR : MWAIT;
                end else if (inp_branch_taken) begin
                    state_nxt = RUN;
                    lcnt_nxt  = '0;
                end else if (state == LSTALL) begin
                    if (lcnt <= 4'd1) begin
                        state_nxt = RUN;
                        lcnt_nxt  = '0;
                    end else begin
                        lcnt_nxt = lcnt - 4'd1;
                    end
                end else if (load_hit && (LOAD_STALL_CYCLES > 1)) begin
                    state_nxt = LSTALL;
                    lcnt_nxt  = LCNT_LOAD;
                end
            end
            MWAIT: begin
                if (inp_mem_ready) begin
                    tcnt_nxt  = '0;
                    state_nxt = (lcnt != '0) ? LSTALL : RUN;
                end else if (tcnt_inc >= TIMEOUT) begin
                    state_nxt = ERR;
                end else begin
                    tcnt_nxt = tcnt_inc[15:0];
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Mealy pipeline controls; reset forces the free-running values immediately
    always_comb begin
        out_pc_write     = 1'b1;
        out_if_id_write  = 1'b1;
        out_id_ex_write  = 1'b1;
        out_if_id_flush  = 1'b0;
        out_id_ex_bubble = 1'b0;
        if (inp_reset_n) begin
            case (state)
                RUN, LSTALL: begin
                    if (mem_wait) begin
                        out_pc_write    = 1'b0;
                        out_if_id_write = 1'b0;
                        out_id_ex_write = 1'b0;
                    end else if (inp_branch_taken) begin
                        out_if_id_flush  = 1'b1;
                        out_id_ex_bubble = 1'b1;
                    end else if ((state == LSTALL) || load_hit) begin
                        out_pc_write     = 1'b0;
                        out_if_id_write  = 1'b0;
                        out_id_ex_bubble = 1'b1;
                    end
                end
                default: begin
                    // MWAIT and ERR: everything held, branch ignored
                    out_pc_write    = 1'b0;
                    out_if_id_write = 1'b0;
                    out_id_ex_write = 1'b0;
                end
            endcase
        end
    end

    // ERR is left only through reset, so the flag is sticky by construction
    assign out_mem_error = (state == ERR);

    // Saturating count of cycles in which the PC did not advance; clear wins
    always_ff @(posedge inp_clk or negedge inp_reset_n) begin
        if (!inp_reset_n) begin
            out_stall_cycles <= '0;
        end else if (inp_clr_cnt) begin
            out_stall_cycles <= '0;
        end else if (!out_pc_write && (out_stall_cycles != '1)) begin
            out_stall_cycles <= out_stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each driven cycle pushes the reference
// model's expected controls; a negedge monitor pops and compares.
module tb_hazard_ctrl;
    import riscs_pipe_pkg::*;

    localparam int LSC = 2;
    localparam int TO  = 8;
    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [2:0]    rs1, rs2, rd;
    logic          u2, mr, br, mq, my, clr;
    logic          pc_w, ifid_w, ifid_fl, idex_w, idex_bub, mem_err;
    logic [CW-1:0] stall_cnt;

    hazard_ctrl #(
        .REG_AW            (3),
        .LOAD_STALL_CYCLES (LSC),
        .MEM_TIMEOUT       (TO),
        .CNT_W             (CW)
    ) dut (
        .inp_clk            (clk),
        .inp_reset_n        (rst_n),
        .inp_if_id_rs1      (rs1),
        .inp_if_id_rs2      (rs2),
        .inp_uses_rs2       (u2),
        .inp_id_ex_rd       (rd),
        .inp_id_ex_mem_read (mr),
        .inp_branch_taken   (br),
        .inp_mem_req        (mq),
        .inp_mem_ready      (my),
        .inp_clr_cnt        (clr),
        .out_pc_write       (pc_w),
        .out_if_id_write    (ifid_w),
        .out_if_id_flush    (ifid_fl),
        .out_id_ex_write    (idex_w),
        .out_id_ex_bubble   (idex_bub),
        .out_mem_error      (mem_err),
        .out_stall_cycles   (stall_cnt)
    );

    typedef struct packed {
        logic          pc;
        logic          ifid;
        logic          flush;
        logic          idex;
        logic          bubble;
        logic          err;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: owed bubbles, ongoing memory wait, dead pipeline, stall count
    int owed, waited, cnt_m;
    bit waiting, dead;

    task automatic model_reset();
        owed = 0; waited = 0; cnt_m = 0; waiting = 0; dead = 0;
    endtask

    task automatic step(input bit rst_b, input logic [2:0] a1, input logic [2:0] a2,
                        input bit use2, input logic [2:0] d, input bit ld,
                        input bit brt, input bit req, input bit rdy, input bit cc);
        obs_t e;
        bit   pc, ifid, fl, idx, bub, hit, err_now;
        @(posedge clk);
        #1;
        rst_n = rst_b; rs1 = a1; rs2 = a2; u2 = use2; rd = d;
        mr = ld; br = brt; mq = req; my = rdy; clr = cc;
        cyc++;
        if (!rst_b) begin
            model_reset();
            e = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0};
        end else begin
            pc = 1; ifid = 1; fl = 0; idx = 1; bub = 0;
            err_now = dead;
            hit = ld && (d != 0) && ((d == a1) || (use2 && (d == a2)));
            if (dead) begin
                pc = 0; ifid = 0; idx = 0;
            end else if (waiting) begin
                pc = 0; ifid = 0; idx = 0;
                if (rdy) begin
                    waiting = 0; waited = 0;
                end else begin
                    waited++;
                    if (waited >= TO) dead = 1;
                end
            end else if (req && !rdy) begin
                pc = 0; ifid = 0; idx = 0;
                waiting = 1; waited = 1;
                if (waited >= TO) dead = 1;
            end else if (brt) begin
                fl = 1; bub = 1; owed = 0;
            end else if (owed > 0) begin
                pc = 0; ifid = 0; bub = 1; owed--;
            end else if (hit) begin
                pc = 0; ifid = 0; bub = 1; owed = LSC - 1;
            end
            e = '{pc, ifid, fl, idx, bub, err_now, CW'(cnt_m)};
            if (cc) cnt_m = 0;
            else if (!pc && cnt_m < CNT_MAX) cnt_m++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit cc);
        step(1, 3'd1, 3'd2, 0, 3'd0, 0, 0, 0, 1, cc);
    endtask

    task automatic rand_step(input bit rst_b);
        step(rst_b, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 30) == 0));
    endtask

    task automatic dcheck(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Monitor: controls are valid every cycle, compared mid-cycle
    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{pc_w, ifid_w, ifid_fl, idex_w, idex_bub, mem_err, stall_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctrl cycle %0d: got pc=%b ifid=%b fl=%b idex=%b bub=%b err=%b cnt=%0d, expected pc=%b ifid=%b fl=%b idex=%b bub=%b err=%b cnt=%0d",
                         cyc, a.pc, a.ifid, a.flush, a.idex, a.bubble, a.err, a.cnt,
                         e.pc, e.ifid, e.flush, e.idex, e.bubble, e.err, e.cnt);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; rs1 = 0; rs2 = 0; rd = 0; u2 = 0; mr = 0; br = 0; mq = 0; my = 1; clr = 0;
        model_reset();

        // reset held with random inputs
        repeat (3) rand_step(0);
        idle(0);

        // load-use with a two-cycle stall, then rd=0 never stalls
        idle(1);
        step(1, 3'd3, 3'd1, 0, 3'd3, 1, 0, 0, 1, 0);
        idle(0); idle(0); idle(0);
        @(negedge clk) dcheck("loaduse_cnt", int'(stall_cnt), 2);
        idle(1);
        step(1, 3'd0, 3'd0, 1, 3'd0, 1, 0, 0, 1, 0);
        idle(0);
        @(negedge clk) dcheck("rd0_cnt", int'(stall_cnt), 0);

        // branch and load-use in the same cycle
        step(1, 3'd1, 3'd5, 1, 3'd5, 1, 1, 0, 1, 0);
        idle(0);
        @(negedge clk) dcheck("branch_no_stall", int'(pc_w), 1);

        // four wait cycles then ready: five frozen cycles
        idle(1);
        repeat (4) step(1, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1, 0, 0);
        step(1, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1, 1, 0);
        idle(0);
        @(negedge clk) dcheck("memwait_cnt", int'(stall_cnt), 5);

        // saturation then clear
        repeat (20) step(1, 3'd4, 3'd0, 0, 3'd4, 1, 0, 0, 1, 0);
        idle(0);
        @(negedge clk) dcheck("sat_cnt", int'(stall_cnt), CNT_MAX);
        idle(1);
        idle(0);
        @(negedge clk) dcheck("clr_cnt", int'(stall_cnt), 0);

        // timeout after eight wait cycles, sticky until reset
        repeat (7) step(1, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1, 0, 0);
        @(negedge clk) dcheck("err_before_timeout", int'(mem_err), 0);
        step(1, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1, 0, 0);
        idle(0);
        @(negedge clk) dcheck("err_set", int'(mem_err), 1);
        repeat (3) rand_step(1);
        @(negedge clk) dcheck("err_sticky", int'(mem_err), 1);
        step(0, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1, 0, 0);
        @(negedge clk) dcheck("err_reset", int'(mem_err), 0);
        idle(0);

        // randomized traffic with occasional resets (always recovers from ERR)
        for (int i = 0; i < 2500; i++) begin
            if ((dead && $urandom_range(0, 4) == 0) || $urandom_range(0, 400) == 0)
                rand_step(0);
            else
                rand_step(1);
        end

        idle(0);
        @(negedge clk);
        @(negedge clk);
        dcheck("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
